// File: rtl/fib_stream_monitor.sv
// fib_stream_monitor
// ------------------
// Checks a stream of Fibonacci terms from the generator. A start pulse
// captures the expected term count n. After that, every accepted in_valid
// beat is compared with F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2) mod 2^WIDTH.
// The recurrence is evaluated on the terms actually received, so one bad
// term only disturbs its own index and the indices that depend on it.
//
// Optional feature: define FIB_MON_OVF_CHECK_EN to compute the full
// WIDTH+1-bit sum in RUN and raise a sticky ovf flag on carry-out.
// Without the macro, ovf is tied to 0.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    one-cycle pulse; samples n and (re)starts a run
//   n        number of terms expected in the run
//   in_valid qualifies in_data
//   in_data  term from the generator
//   busy     run in progress
//   done     one-cycle pulse after the n-th accepted term
//   error    sticky mismatch flag, cleared by start
//   err_idx  index of the first mismatching term
//   count    terms accepted in the current or last run
//   ovf      sticky carry-out flag (optional feature)
module fib_stream_monitor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] err_idx,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, EXP0, EXP1, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] err_idx_reg;
  logic             error_reg;
  logic             done_reg;

  logic             accept;
  logic [WIDTH-1:0] count_inc;
  logic             last_beat;
  logic [WIDTH-1:0] sum_mod;
  logic [WIDTH-1:0] expected;

`ifdef FIB_MON_OVF_CHECK_EN
  logic [WIDTH:0]   sum_full;
  logic             ovf_reg;
  assign sum_full = {1'b0, a_reg} + {1'b0, b_reg};
  assign sum_mod  = sum_full[WIDTH-1:0];
`else
  assign sum_mod  = a_reg + b_reg;
`endif

  // start takes priority: a beat arriving with start is dropped.
  assign accept    = in_valid && !start && (state_reg != IDLE);
  assign count_inc = count_reg + 1'b1;
  assign last_beat = (count_inc == n_reg);

  always_comb begin
    expected = '0;
    case (state_reg)
      EXP0:    expected = '0;
      EXP1:    expected = {{(WIDTH-1){1'b0}}, 1'b1};
      RUN:     expected = sum_mod;
      default: expected = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = (n == '0) ? IDLE : EXP0;
    end else if (accept) begin
      case (state_reg)
        EXP0:    state_next = last_beat ? IDLE : EXP1;
        EXP1:    state_next = last_beat ? IDLE : RUN;
        RUN:     state_next = last_beat ? IDLE : RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      count_reg   <= '0;
      err_idx_reg <= '0;
      error_reg   <= 1'b0;
      done_reg    <= 1'b0;
`ifdef FIB_MON_OVF_CHECK_EN
      ovf_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        n_reg       <= n;
        a_reg       <= '0;
        b_reg       <= '0;
        count_reg   <= '0;
        err_idx_reg <= '0;
        error_reg   <= 1'b0;
        // A zero-length run completes immediately.
        done_reg    <= (n == '0);
`ifdef FIB_MON_OVF_CHECK_EN
        ovf_reg     <= 1'b0;
`endif
      end else if (accept) begin
        // History follows received data, not the expected values.
        a_reg     <= (state_reg == EXP0) ? '0 : b_reg;
        b_reg     <= in_data;
        count_reg <= count_inc;
        if ((in_data != expected) && !error_reg) begin
          error_reg   <= 1'b1;
          err_idx_reg <= count_reg;
        end
        if (last_beat) begin
          done_reg <= 1'b1;
        end
`ifdef FIB_MON_OVF_CHECK_EN
        if ((state_reg == RUN) && sum_full[WIDTH]) begin
          ovf_reg <= 1'b1;
        end
`endif
      end
    end
  end

  // Outputs
  always_comb begin
    busy    = (state_reg != IDLE);
    done    = done_reg;
    error   = error_reg;
    err_idx = err_idx_reg;
    count   = count_reg;
`ifdef FIB_MON_OVF_CHECK_EN
    ovf     = ovf_reg;
`else
    ovf     = 1'b0;
`endif
  end

endmodule
